// File: rtl/pc_mem_arbiter.sv
// Shared memory port arbiter for the pipelined computer.
// The instruction-fetch (IF, read-only) and data-memory (DM, read/write)
// stages share one memory port. A fixed-latency FSM issues one access at a
// time, captures read data into the owner's register and returns a one-cycle
// ready pulse. DM wins ties. A burst counter caps consecutive DM grants while
// a fetch is waiting, so the fetch stage cannot starve.
//
// Handshake: a requester raises req with address/data stable and holds req
// until it sees its ready pulse. Address/data are sampled only in the grant
// cycle (IDLE). Ready is a single-cycle pulse in RESP and is not a backpressure
// signal. Dropping req mid-access does not abort; ready still pulses.
module pc_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int LAT          = 1,
    parameter int MAX_DM_BURST = 4
) (
    input  logic          clock,
    input  logic          resetn,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ready,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          if_stall,
    output logic          dm_stall,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter preload: WAIT lasts LAT cycles, capture happens when it hits 0.
    localparam logic [3:0] CNT_INIT  = 4'(LAT - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

    state_t     state;
    logic [3:0] cnt;
    logic [3:0] burst;
    logic       owner;      // 1 = DM owns the current access, 0 = IF

    logic       grant_dm;
    logic       grant_if;

    // Grant decision; only acted on while the FSM is in IDLE.
    always_comb begin
        grant_dm = dm_req & (~if_req | (burst < BURST_MAX));
        grant_if = ~grant_dm & if_req;
    end

    // Access sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE, all outputs registered.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            burst     <= '0;
            owner     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        owner     <= 1'b1;
                        mem_addr  <= dm_addr;
                        mem_we    <= dm_we;
                        mem_wdata <= dm_wdata;
                        mem_en    <= 1'b1;
                        state     <= ISSUE;
                        // Count DM grants only while a fetch is being held off.
                        if (if_req) begin
                            if (burst != 4'hF) begin
                                burst <= burst + 4'd1;
                            end
                        end else begin
                            burst <= '0;
                        end
                    end else if (grant_if) begin
                        owner     <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_en    <= 1'b1;
                        burst     <= '0;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt    <= CNT_INIT;
                    state  <= WAIT;
                end

                WAIT: begin
                    if (cnt == 4'd0) begin
                        // mem_rdata is valid this cycle; writes leave rdata alone.
                        if (!mem_we) begin
                            if (owner) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        if (owner) begin
                            dm_ready <= 1'b1;
                        end else begin
                            if_ready <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                RESP: begin
                    // Completed request may still be high here; it is not reissued.
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stalls follow the requests directly so pipeline control sees them in the same cycle.
    always_comb begin
        if_stall = if_req & ~if_ready;
        dm_stall = dm_req & ~dm_ready;
        busy     = (state != IDLE);
    end

    // The issue strobe coincides exactly with the ISSUE state.
    a_issue_strobe: assert property (@(posedge clock) disable iff (!resetn)
        mem_en == (state == ISSUE));

    // Ready pulses coincide exactly with the RESP state.
    a_ready_resp: assert property (@(posedge clock) disable iff (!resetn)
        (if_ready | dm_ready) == (state == RESP));

    // Only one requester is ever completed at a time.
    a_ready_excl: assert property (@(posedge clock) disable iff (!resetn)
        !(if_ready && dm_ready));

endmodule

// File: doc/pc_mem_arbiter.md
Name: pc_mem_arbiter

Overview:
- Sequences a single shared memory port between the instruction-fetch stage (IF, read-only) and the data-memory stage (DM, read/write) of the pipelined computer.
- Runs a fixed-latency access FSM and returns per-requester ready pulses and read data.
- Generates the stall signals the pipeline control uses to freeze the PC and pipeline registers while an access is outstanding.
- Data-stage accesses have priority; a burst limit prevents fetch starvation.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- LAT, 1, memory read latency in cycles, measured from the issue cycle to the cycle mem_rdata is valid. Legal range is 1..15.
- MAX_DM_BURST, 4, maximum consecutive DM grants while if_req is pending. Legal range is 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  synchronous reset, active-low.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word; valid while if_ready=1, then holds its value.
- if_ready  out  1  one-cycle completion pulse for the fetch access.
- dm_req  in  1  data request; held high until dm_ready.
- dm_we  in  1  1=write, 0=read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; valid while dm_ready=1, then holds its value.
- dm_ready  out  1  one-cycle completion pulse (read or write).
- mem_en  out  1  registered; one-cycle issue strobe to memory.
- mem_we  out  1  registered; write enable, qualified by mem_en.
- mem_addr  out  AW  registered address.
- mem_wdata  out  DW  registered write data.
- mem_rdata  in  DW  memory read data; valid exactly LAT cycles after the mem_en cycle.
- if_stall  out  1  combinational: if_req & ~if_ready.
- dm_stall  out  1  combinational: dm_req & ~dm_ready.
- busy  out  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset values (resetn=0 at an edge):
  - FSM goes to IDLE.
  - mem_en, mem_we, if_ready and dm_ready are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - The latency counter, burst counter and owner register are 0.
  - Reset mid-access abandons the access: no ready pulse is issued, and a late mem_rdata is ignored.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - Requests are sampled only in IDLE.
  - If dm_req=1 and (if_req=0 or burst<MAX_DM_BURST), grant DM. A DM grant increments burst (saturating) only when if_req=1; otherwise burst clears to 0.
  - Else if if_req=1, grant IF and clear burst to 0.
  - On any grant, register owner, mem_addr, mem_we (dm_we for DM, 0 for IF) and mem_wdata, set mem_en=1, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - mem_en=1 for exactly this cycle.
  - Load the counter with LAT-1; if LAT=1, go directly to capture.
  - Otherwise go to WAIT.
  - mem_en returns to 0 on exit.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle mem_rdata is valid (LAT cycles after ISSUE), capture it into the owner's rdata register, for reads only, and go to RESP.
  - For writes, rdata registers are unchanged.
- RESP:
  - The owner's ready=1 for exactly one cycle.
  - Next state is IDLE unconditionally. A request still high during RESP is the completed one and is not reissued.
- Latency from the first cycle of req=1 (FSM idle) to the ready pulse is LAT+2 cycles, i.e. 3 for LAT=1.
- Back-to-back throughput is one access per LAT+3 cycles (IDLE sample cycle included).
- Simultaneous requests: DM wins unless burst=MAX_DM_BURST, in which case IF wins and burst clears.
- A request deasserted mid-access does not abort. The access completes and ready still pulses; the requester ignores it.
- Request inputs are sampled only at grant; changes to address/data after grant have no effect.
- The stall outputs are purely combinational, with no extra cycle.

Test Plan:
- Reset then single IF read: LAT=1, if_req=1, if_addr=0x40, memory returns 0x8C010004. Required: mem_en high only in cycle 1 with mem_addr=0x40 and mem_we=0; if_ready pulses in cycle 3; if_rdata=0x8C010004; if_stall=1 in cycles 0-2.
- DM write: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF. Required: mem_we=1, mem_wdata=0xDEADBEEF in the ISSUE cycle; dm_ready pulses once; dm_rdata unchanged from its prior value.
- Simultaneous requests, LAT=3: if_req and dm_req both rise in cycle 0 (dm read 0x200). Required: DM is served first and dm_ready arrives in cycle 5. The IF grant is sampled in cycle 6 and if_ready arrives in cycle 11.
- Starvation limit: MAX_DM_BURST=2, if_req held high, dm_req re-raised immediately after each dm_ready. Required grant order is DM, DM, IF, DM, DM, IF.
- Reset mid-access: LAT=4, assert resetn=0 in the WAIT cycle after ISSUE, release after 1 cycle. Required: no ready pulse; all outputs at reset values; a fresh IF request then completes normally in LAT+2 cycles.
- LAT=15 boundary: a DM read completes with dm_ready exactly 17 cycles after request; busy=1 throughout, then 0 in the following cycle.
